exmem_stream_reader: RTL and testbench
======================================

// Module: exmem_stream_reader
// PURPOSE
//  Bus initiator for the exmem block RAM: streams LENGTH words from a base address out on a
//  valid/ready port (audio playback / DAC path). Read-only; drives RAM en/adr, never writes.
//  Handles the RAM's 1-cycle registered read latency. A 2-entry output buffer keeps
//  1 word/cycle under continuous ready. Returns to idle when done or aborted.
// PARAMETERS
//  WIDTH          32  data word width; must equal the RAM's WIDTH
//  RAM_ADDR_BITS  10  RAM address width; addresses wrap modulo 2**RAM_ADDR_BITS
// PORTS
//  clk        in   1               system clock, all logic on posedge
//  reset_n    in   1               asynchronous active-low reset
//  start      in   1               start request; sampled only in IDLE
//  abort      in   1               synchronous abort; wins over every other event
//  base_adr   in   RAM_ADDR_BITS   first word address, captured with start
//  length     in   RAM_ADDR_BITS+1 word count, 0..2**RAM_ADDR_BITS, captured with start
//  busy       out  1               high from the cycle after start until done/abort
//  done       out  1               1-cycle pulse when the last word is accepted
//  mem_en     out  1               RAM enable (one read issued per cycle it is high)
//  memwrite   out  1               RAM write enable; tied 0
//  mem_adr    out  RAM_ADDR_BITS   RAM address
//  memdata    in   WIDTH           RAM read data, valid the cycle after mem_en
//  s_valid    out  1               output word valid
//  s_data     out  WIDTH           output word
//  s_last     out  1               marks the final word of the transfer
//  s_ready    in   1               consumer accepts when s_valid&s_ready (a "pop")
// BEHAVIOUR
//  Reset (async): state=IDLE; busy, done, mem_en, memwrite, s_valid and s_last = 0;
//   mem_adr=0, s_data=0; buffer empty; in-flight flag 0.
//  States: IDLE -> RUN on start (length>0). IDLE -> DONE on start with length==0.
//   RUN -> DRAIN when the final read is issued.
//   DRAIN -> DONE when the final word is popped. DONE -> IDLE after exactly 1 cycle.
//   abort in any state -> IDLE next edge.
//  start while busy is ignored. Latched base and length are unaffected by input changes mid-run.
//  Issue rule (RUN): mem_en=1 iff count + inflight - pop < 2.
//   count = buffer entries; inflight = read issued last cycle.
//   mem_adr advances by 1 per issued read, wraps 2**RAM_ADDR_BITS-1 -> 0.
//   When mem_en=0, mem_adr holds its value.
//  Capture: the cycle after each issue, memdata is written into the buffer (FIFO order).
//   The buffer never overflows by construction; overflow is an assertion failure.
//  Output: s_valid = (count>0). s_data/s_last = head entry, held stable while s_valid && !s_ready.
//   s_last=1 only on the word with index length-1.
//  Latency: start at edge E0 -> busy=1 and first mem_en in cycle 1.
//   First s_valid in cycle 3.
//   With s_ready held 1 the stream is gap-free, 1 word/cycle.
//  done: pulses in the cycle after the s_last pop; busy falls in that same cycle.
//   For length==0: done pulses in cycle 1, no mem_en issued.
//  abort: mem_en=0 the next cycle, buffer flushed, any in-flight read data discarded.
//   s_valid=0 and busy=0 the next cycle. No done pulse.
//  length==2**RAM_ADDR_BITS: reads every word once, starting at base_adr, with wrap.
// TESTING
//  1 base=0x010,len=4,RAM[k]=k,s_ready=1 -> s_data 0x10..0x13 in cycles 3..6; s_last on 0x13; done in cycle 7
//  2 base=0x3FE,len=4 -> mem_adr 3FE,3FF,000,001; data order matches RAM contents
//  3 len=8 with s_ready toggling 1,0,0,1...: no lost/duplicated words, data held while stalled, count<=2 always
//  4 len=0 -> done pulse in cycle 1; mem_en never asserted; s_valid stays 0
//  5 len=16, abort at cycle 5 -> next cycle mem_en=0,s_valid=0,busy=0,no done; new start runs normally
//  6 reset_n low mid-transfer -> all outputs reset immediately (async); start after release accepted

Source files
------------

// File: rtl/exmem_stream_reader.sv
// exmem_stream_reader: streams a block of words from the exmem RAM onto a
// valid/ready port. Read-only initiator; 1-cycle RAM read latency is absorbed
// by a 2-entry output buffer so continuous ready gives 1 word per cycle.
module exmem_stream_reader #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned RAM_ADDR_BITS = 10
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [RAM_ADDR_BITS-1:0] base_adr,
    input  logic [RAM_ADDR_BITS:0]   length,
    output logic                     busy,
    output logic                     done,
    output logic                     mem_en,
    output logic                     memwrite,
    output logic [RAM_ADDR_BITS-1:0] mem_adr,
    input  logic [WIDTH-1:0]         memdata,
    output logic                     s_valid,
    output logic [WIDTH-1:0]         s_data,
    output logic                     s_last,
    input  logic                     s_ready
);

    localparam int unsigned LW = RAM_ADDR_BITS + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state;
    logic [LW-1:0]      issue_left;     // reads still to be issued
    logic [1:0]         count;          // buffer occupancy (head is s_data/s_last)
    logic               inflight;       // read issued last cycle, data on memdata now
    logic               inflight_last;  // that read was the final word
    logic [WIDTH-1:0]   data1;          // second buffer entry
    logic               last1;

    logic               pop;
    logic               push;
    logic [2:0]         occ;
    logic [1:0]         count_nxt;

    assign memwrite = 1'b0;

    // Issue decision is combinational so a pop this cycle frees room for a
    // read this cycle; this is what makes the stream gap-free with only 2 slots.
    always_comb begin
        pop       = s_valid & s_ready;
        push      = inflight;
        occ       = 3'(count) + 3'(inflight) - 3'(pop);
        mem_en    = (state == ST_RUN) && (occ < 3'd2);
        count_nxt = count + {1'b0, push} - {1'b0, pop};
    end

    // Control FSM, address generation and output buffer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            mem_adr       <= '0;
            issue_left    <= '0;
            count         <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            s_valid       <= 1'b0;
            s_data        <= '0;
            s_last        <= 1'b0;
            data1         <= '0;
            last1         <= 1'b0;
        end else if (abort) begin
            // abort drops everything, including the read in flight
            state         <= ST_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            count         <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            s_valid       <= 1'b0;
            s_last        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (length == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= ST_RUN;
                            busy       <= 1'b1;
                            mem_adr    <= base_adr;
                            issue_left <= length;
                        end
                    end
                end
                ST_RUN: begin
                    if (mem_en && (issue_left == LW'(1))) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pop && s_last) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            if (mem_en) begin
                mem_adr    <= mem_adr + RAM_ADDR_BITS'(1);
                issue_left <= issue_left - LW'(1);
            end
            inflight      <= mem_en;
            inflight_last <= mem_en && (issue_left == LW'(1));

            // FIFO update: head lives in s_data/s_last, second slot in data1/last1
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        s_data <= memdata;
                        s_last <= inflight_last;
                    end else begin
                        data1 <= memdata;
                        last1 <= inflight_last;
                    end
                end
                2'b01: begin
                    s_data <= data1;
                    s_last <= last1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        s_data <= memdata;
                        s_last <= inflight_last;
                    end else begin
                        s_data <= data1;
                        s_last <= last1;
                        data1  <= memdata;
                        last1  <= inflight_last;
                    end
                end
                default: begin
                end
            endcase
            count   <= count_nxt;
            s_valid <= (count_nxt != 2'd0);
            if (count_nxt == 2'd0) begin
                s_last <= 1'b0;
            end
        end
    end

    // The issue rule must keep the buffer from ever exceeding two entries.
    always_ff @(posedge clk) begin
        if (reset_n && !abort) begin
            assert (!(push && !pop && (count == 2'd2)));
        end
    end

endmodule

// File: tb/tb_exmem_stream_reader.sv
// Bench for exmem_stream_reader: RAM model with registered read, a
// transfer-level reference model and a per-cycle compare process.
module tb_exmem_stream_reader;

    localparam int unsigned W     = 32;
    localparam int unsigned AB    = 10;
    localparam int unsigned DEPTH = 1 << AB;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          abort;
    logic [AB-1:0] base_adr;
    logic [AB:0]   length;
    logic          busy;
    logic          done;
    logic          mem_en;
    logic          memwrite;
    logic [AB-1:0] mem_adr;
    logic [W-1:0]  memdata = '0;
    logic          s_valid;
    logic [W-1:0]  s_data;
    logic          s_last;
    logic          s_ready;

    exmem_stream_reader #(.WIDTH(W), .RAM_ADDR_BITS(AB)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .base_adr(base_adr), .length(length), .busy(busy), .done(done),
        .mem_en(mem_en), .memwrite(memwrite), .mem_adr(mem_adr),
        .memdata(memdata), .s_valid(s_valid), .s_data(s_data),
        .s_last(s_last), .s_ready(s_ready)
    );

    always #5 clk = ~clk;

    // RAM with 1-cycle registered read
    logic [W-1:0] ram [DEPTH];
    always @(posedge clk) if (mem_en) memdata <= ram[mem_adr];

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
        n_cmp++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, a, e, $time);
        end
    endtask

    // Reference model state: a transfer is a list of words ram[(base+i)%DEPTH]
    bit m_act = 0, m_done = 0, prev_stall = 0, prev_abort = 0;
    int m_base = 0, m_len = 0, m_iss = 0, m_pop = 0;
    int cyc = 0, start_cyc = 0, rdy_mode = 0, rdy_cnt = 0;
    // per-transfer statistics used by literal checks
    int first_en, first_val, done_at, last_pop_at, n_en, n_val, n_pop;
    logic [W-1:0] first_pop_data, last_pop_data;
    logic last_pop_last;
    int adr_log[$];

    // Compare process: outputs are checked mid-cycle, model advances per edge
    always @(negedge clk) begin
        int rel, iss_before;
        bit pop, nxt_act, nxt_done;
        cyc++;
        if (!reset_n) begin
            m_act = 0; m_done = 0; prev_stall = 0; prev_abort = 0;
        end else begin
            rel = cyc - start_cyc;
            iss_before = m_iss;
            chk("busy", busy, m_act);
            chk("done", done, m_done);
            chk("memwrite", memwrite, 0);
            if (done && done_at < 0) done_at = rel;
            if (mem_en) begin
                n_en++;
                if (first_en < 0) first_en = rel;
                adr_log.push_back(int'(mem_adr));
                chk("en_when_needed", m_act && (m_iss < m_len), 1);
                if (m_act && m_iss < m_len) chk("mem_adr", mem_adr, (m_base + m_iss) % DEPTH);
                m_iss++;
            end
            if (s_valid) begin
                n_val++;
                if (first_val < 0) first_val = rel;
                chk("valid_when_data", m_act && (m_pop < iss_before), 1);
                if (m_act && m_pop < m_len) begin
                    chk("s_data", s_data, ram[(m_base + m_pop) % DEPTH]);
                    chk("s_last", s_last, m_pop == m_len - 1);
                end
            end else if (prev_stall && !prev_abort) begin
                chk("valid_held", s_valid, 1);
            end
            if (rdy_mode == 0 && m_act && rel >= 3 && m_pop < m_len && !abort && !prev_abort)
                chk("gap_free", s_valid, 1);

            pop = s_valid && s_ready;
            prev_stall = s_valid && !s_ready && m_act;
            prev_abort = abort;

            nxt_act = m_act; nxt_done = 0;
            if (abort) begin
                nxt_act = 0;
            end else if (m_act) begin
                if (pop) begin
                    n_pop++;
                    if (n_pop == 1) first_pop_data = s_data;
                    last_pop_data = s_data; last_pop_last = s_last; last_pop_at = rel;
                    m_pop++;
                    if (m_pop == m_len) begin nxt_act = 0; nxt_done = 1; end
                end
            end else if (!m_done && start) begin
                start_cyc = cyc;
                m_base = int'(base_adr); m_len = int'(length); m_iss = 0; m_pop = 0;
                if (m_len == 0) nxt_done = 1; else nxt_act = 1;
            end
            m_act = nxt_act; m_done = nxt_done;
        end
    end

    // s_ready pattern generator: 0 = always ready, 1 = random, 2 = 1,0,0 repeating
    initial begin
        s_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: s_ready = 1'b1;
                1: s_ready = 1'($urandom_range(0, 1));
                default: s_ready = (rdy_cnt % 3 == 0);
            endcase
            rdy_cnt++;
        end
    end

    task automatic fill_ram(input bit identity);
        for (int i = 0; i < DEPTH; i++) ram[i] = identity ? W'(i) : W'($urandom);
    endtask

    task automatic do_start(input int b, input int l);
        first_en = -1; first_val = -1; done_at = -1; last_pop_at = -1;
        n_en = 0; n_val = 0; n_pop = 0; adr_log.delete();
        @(posedge clk); #1;
        base_adr = AB'(b); length = (AB + 1)'(l); start = 1'b1; rdy_cnt = 0;
        @(posedge clk); #1;
        start = 1'b0;
        base_adr = AB'($urandom); length = (AB + 1)'($urandom);
    endtask

    task automatic wait_end(input string name);
        bit fin = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk); #1;
            if (!m_act && !m_done) begin fin = 1; break; end
        end
        chk({name, "_finished"}, fin, 1);
        repeat (2) @(posedge clk);
    endtask

    task automatic do_abort_at(input int n);
        repeat (n - 1) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; base_adr = '0; length = '0;
        first_en = -1; first_val = -1; done_at = -1; last_pop_at = -1;
        n_en = 0; n_val = 0; n_pop = 0;
        fill_ram(1);
        #2;
        chk("rst_busy", busy, 0);     chk("rst_done", done, 0);
        chk("rst_mem_en", mem_en, 0); chk("rst_s_valid", s_valid, 0);
        chk("rst_mem_adr", mem_adr, 0); chk("rst_s_data", s_data, 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // 1: base 0x10, length 4, RAM[k]=k, always ready
        rdy_mode = 0;
        do_start(32'h10, 4);
        wait_end("t1");
        chk("t1_first_en_cycle", first_en, 1);
        chk("t1_first_valid_cycle", first_val, 3);
        chk("t1_last_pop_cycle", last_pop_at, 6);
        chk("t1_done_cycle", done_at, 7);
        chk("t1_first_word", first_pop_data, 32'h10);
        chk("t1_last_word", last_pop_data, 32'h13);
        chk("t1_last_flag", last_pop_last, 1);
        chk("t1_reads", n_en, 4);

        // 2: address wrap
        fill_ram(0);
        do_start(32'h3FE, 4);
        wait_end("t2");
        chk("t2_reads", adr_log.size(), 4);
        if (adr_log.size() == 4) begin
            chk("t2_adr0", adr_log[0], 32'h3FE); chk("t2_adr1", adr_log[1], 32'h3FF);
            chk("t2_adr2", adr_log[2], 32'h000); chk("t2_adr3", adr_log[3], 32'h001);
        end
        chk("t2_pops", n_pop, 4);

        // 3: stalling consumer, plus a start pulse while busy that must be ignored
        rdy_mode = 2;
        do_start(32'h155, 8);
        repeat (2) @(posedge clk);
        #1 start = 1'b1; base_adr = '0; length = 11'd3;
        @(posedge clk); #1 start = 1'b0;
        wait_end("t3");
        chk("t3_pops", n_pop, 8);
        chk("t3_reads", n_en, 8);

        // 4: zero length
        rdy_mode = 0;
        do_start(32'h20, 0);
        wait_end("t4");
        chk("t4_done_cycle", done_at, 1);
        chk("t4_reads", n_en, 0);
        chk("t4_valids", n_val, 0);

        // 5: abort at cycle 5 of a 16-word transfer, then a normal run
        do_start(32'h40, 16);
        do_abort_at(5);
        @(negedge clk);
        chk("t5_mem_en_after_abort", mem_en, 0);
        chk("t5_valid_after_abort", s_valid, 0);
        chk("t5_busy_after_abort", busy, 0);
        repeat (4) @(posedge clk);
        chk("t5_no_done", done_at, -1);
        do_start(32'h50, 6);
        wait_end("t5b");
        chk("t5b_pops", n_pop, 6);
        chk("t5b_done_cycle", done_at, 9);

        // 6: asynchronous reset mid-transfer
        rdy_mode = 1;
        do_start(32'h100, 30);
        repeat (6) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("t6_busy", busy, 0);       chk("t6_done", done, 0);
        chk("t6_mem_en", mem_en, 0);   chk("t6_s_valid", s_valid, 0);
        chk("t6_s_last", s_last, 0);   chk("t6_mem_adr", mem_adr, 0);
        chk("t6_s_data", s_data, 0);
        @(posedge clk); #1 reset_n = 1'b1;
        do_start(32'h200, 5);
        wait_end("t6b");
        chk("t6b_pops", n_pop, 5);

        // randomized transfers, some aborted
        for (int k = 0; k < 8; k++) begin
            int b, l;
            bit ab;
            fill_ram(0);
            b = $urandom_range(0, DEPTH - 1);
            l = $urandom_range(1, 40);
            rdy_mode = $urandom_range(0, 2);
            ab = ($urandom_range(0, 3) == 0);
            do_start(b, l);
            if (ab) do_abort_at($urandom_range(1, 10));
            wait_end("rand");
            if (!ab) chk("rand_pops", n_pop, l);
        end

        // full-memory transfer with wrap
        rdy_mode = 0;
        fill_ram(0);
        do_start(32'h200, DEPTH);
        wait_end("full");
        chk("full_reads", n_en, DEPTH);
        chk("full_pops", n_pop, DEPTH);
        chk("full_done_cycle", done_at, DEPTH + 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
